// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared defaults and write-port arbitration helper for regfile_mp.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_AW     = 3;
  localparam int MAX_NREAD  = 4;
  localparam int MAX_NWRITE = 2;
  localparam int WIN_W      = 1;

  // Highest-indexed hitting write port wins; result is meaningless when no bit is set.
  function automatic logic [WIN_W-1:0] win_port(input logic [MAX_NWRITE-1:0] hits);
    logic [WIN_W-1:0] idx;
    idx = '0;
    for (int j = 0; j < MAX_NWRITE; j++) begin
      if (hits[j]) idx = WIN_W'(j);
    end
    return idx;
  endfunction

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_rd_port.sv
// ============================================================================
// Module : regfile_rd_port
// Brief  : One synchronous read port: write-first bypass, zero register, hold,
//          and (with REGFILE_SCOREBOARD_EN) the registered busy flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int AW       = DEF_AW,
  parameter int NWRITE   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold,
  input  logic [AW-1:0]           raddr,
  input  logic [WIDTH-1:0]        arr_data,
  input  logic [NWRITE-1:0]       wen,
  input  logic [NWRITE*AW-1:0]    waddr,
  input  logic [NWRITE*WIDTH-1:0] wdata,
`ifdef REGFILE_SCOREBOARD_EN
  input  logic                    busy_next,
  output logic                    rbusy,
`endif
  output logic [WIDTH-1:0]        rdata
);

  logic [MAX_NWRITE-1:0] hits;
  logic [WIN_W-1:0]      win;
  logic [WIDTH-1:0]      rd_val;
  logic [WIDTH-1:0]      rdata_d, rdata_q;

  always_comb begin
    hits = '0;
    for (int j = 0; j < NWRITE; j++) begin
      hits[j] = wen[j] && (waddr[j*AW +: AW] == raddr);
    end
    win = win_port(hits);

    rd_val = (|hits) ? wdata[int'(win)*WIDTH +: WIDTH] : arr_data;
    // The zero register must also mask a bypassed write to address 0.
    if ((ZERO_REG != 0) && (raddr == '0)) rd_val = '0;

    rdata_d = hold ? rdata_q : rd_val;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

`ifdef REGFILE_SCOREBOARD_EN
  logic rbusy_d, rbusy_q;

  always_comb begin
    rbusy_d = hold ? rbusy_q : busy_next;
  end

  always_ff @(posedge clk) begin
    if (rst) rbusy_q <= 1'b0;
    else     rbusy_q <= rbusy_d;
  end

  assign rbusy = rbusy_q;
`endif

endmodule : regfile_rd_port

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module : regfile_mp
// Brief  : Multi-port write-first register file with zero register, read hold
//          and debug tap. Define REGFILE_SCOREBOARD_EN for per-register busy bits.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int AW       = DEF_AW,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 1,
  parameter int ZERO_REG = 1,
  parameter int TAP_REG  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold,
  input  logic [NREAD*AW-1:0]     raddr,
  output logic [NREAD*WIDTH-1:0]  rdata,
  input  logic [NWRITE-1:0]       wen,
  input  logic [NWRITE*AW-1:0]    waddr,
  input  logic [NWRITE*WIDTH-1:0] wdata,
`ifdef REGFILE_SCOREBOARD_EN
  input  logic                    claim,
  input  logic [AW-1:0]           claim_addr,
  output logic [NREAD-1:0]        rbusy,
`endif
  output logic [WIDTH-1:0]        tap_val
);

  localparam int DEPTH = 2 ** AW;

  if ((NREAD < 1) || (NREAD > MAX_NREAD)) begin : g_chk_nread
    $error("regfile_mp: NREAD out of range");
  end
  if ((NWRITE < 1) || (NWRITE > MAX_NWRITE)) begin : g_chk_nwrite
    $error("regfile_mp: NWRITE out of range");
  end
  if ((TAP_REG < 0) || (TAP_REG >= DEPTH)) begin : g_chk_tap
    $error("regfile_mp: TAP_REG out of range");
  end
  if ((WIDTH < 1) || (AW < 1)) begin : g_chk_dims
    $error("regfile_mp: WIDTH and AW must be positive");
  end

  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Later ports overwrite earlier ones, so the highest index wins on a conflict.
  always_comb begin
    mem_d = mem_q;
    for (int j = 0; j < NWRITE; j++) begin
      if (wen[j] && !((ZERO_REG != 0) && (waddr[j*AW +: AW] == '0))) begin
        mem_d[waddr[j*AW +: AW]] = wdata[j*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign tap_val = mem_q[TAP_REG];

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] busy_d, busy_q;

  // Writes clear first so a same-cycle claim on the same register wins.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWRITE; j++) begin
      if (wen[j]) busy_d[waddr[j*AW +: AW]] = 1'b0;
    end
    if (claim) busy_d[claim_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end
`endif

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    regfile_rd_port #(
      .WIDTH    (WIDTH),
      .AW       (AW),
      .NWRITE   (NWRITE),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .clk       (clk),
      .rst       (rst),
      .hold      (hold),
      .raddr     (raddr[i*AW +: AW]),
      .arr_data  (mem_q[raddr[i*AW +: AW]]),
      .wen       (wen),
      .waddr     (waddr),
      .wdata     (wdata),
`ifdef REGFILE_SCOREBOARD_EN
      .busy_next (busy_d[raddr[i*AW +: AW]]),
      .rbusy     (rbusy[i]),
`endif
      .rdata     (rdata[i*WIDTH +: WIDTH])
    );
  end

endmodule : regfile_mp

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module : tb_regfile_mp
// Brief  : Directed self-checking bench for regfile_mp (NREAD=2, NWRITE=2).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp;

  localparam int WIDTH  = 16;
  localparam int AW     = 3;
  localparam int NREAD  = 2;
  localparam int NWRITE = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    hold;
  logic [NREAD*AW-1:0]     raddr;
  logic [NREAD*WIDTH-1:0]  rdata;
  logic [NWRITE-1:0]       wen;
  logic [NWRITE*AW-1:0]    waddr;
  logic [NWRITE*WIDTH-1:0] wdata;
  logic [WIDTH-1:0]        tap_val;
`ifdef REGFILE_SCOREBOARD_EN
  logic                    claim;
  logic [AW-1:0]           claim_addr;
  logic [NREAD-1:0]        rbusy;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .WIDTH    (WIDTH),
    .AW       (AW),
    .NREAD    (NREAD),
    .NWRITE   (NWRITE),
    .ZERO_REG (1),
    .TAP_REG  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .raddr      (raddr),
    .rdata      (rdata),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
`ifdef REGFILE_SCOREBOARD_EN
    .claim      (claim),
    .claim_addr (claim_addr),
    .rbusy      (rbusy),
`endif
    .tap_val    (tap_val)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int port, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    wen[port]                = 1'b1;
    waddr[port*AW +: AW]     = a;
    wdata[port*WIDTH +: WIDTH] = d;
  endtask

  function automatic logic [WIDTH-1:0] rd(input int port);
    return rdata[port*WIDTH +: WIDTH];
  endfunction

  initial begin
    rst = 1'b1; hold = 1'b0; raddr = '0; wen = '0; waddr = '0; wdata = '0;
`ifdef REGFILE_SCOREBOARD_EN
    claim = 1'b0; claim_addr = '0;
`endif
    step();
    check("reset_rdata0", rd(0), 16'h0000);
    check("reset_rdata1", rd(1), 16'h0000);
    check("reset_tap", tap_val, 16'h0000);
    rst = 1'b0;

    // Write r5, confirm, then reset clears it even while a write is requested.
    wr(0, 3'd5, 16'hBEEF);
    step();
    wen = '0; raddr[0 +: AW] = 3'd5;
    step();
    check("r5_written", rd(0), 16'hBEEF);
    rst = 1'b1; wr(1, 3'd3, 16'h5A5A); hold = 1'b1;
    step();
    check("rst_dominates_rdata", rd(0), 16'h0000);
    check("rst_dominates_tap", tap_val, 16'h0000);
    rst = 1'b0; wen = '0; hold = 1'b0;
    step();
    check("r5_after_reset", rd(0), 16'h0000);

    // Write-first bypass on a previously zero register.
    wr(0, 3'd4, 16'h1234); raddr[0 +: AW] = 3'd4;
    step();
    check("bypass_r4", rd(0), 16'h1234);
    wen = '0;

    // Zero register on both ports, same cycle as the write and after.
    wr(0, 3'd0, 16'hFFFF); raddr = {3'd0, 3'd0};
    step();
    check("zero_p0_inflight", rd(0), 16'h0000);
    check("zero_p1_inflight", rd(1), 16'h0000);
    wen = '0;
    step();
    check("zero_p0_after", rd(0), 16'h0000);
    check("zero_p1_after", rd(1), 16'h0000);

    // Tap follows r3 one cycle after the write, via port 1.
    wr(1, 3'd3, 16'h3333);
    step();
    check("tap_r3", tap_val, 16'h3333);
    wen = '0;

    // Both ports hit r2: port 1 wins for bypass and array.
    wr(0, 3'd2, 16'h1111); wr(1, 3'd2, 16'h2222); raddr[0 +: AW] = 3'd2;
    step();
    check("conflict_bypass", rd(0), 16'h2222);
    wen = '0; raddr[AW +: AW] = 3'd2;
    step();
    check("conflict_array", rd(1), 16'h2222);
    check("conflict_tap_unchanged", tap_val, 16'h3333);

    // Hold: rdata[1]=AA from r6 stays while r6 is rewritten.
    wr(0, 3'd6, 16'h00AA);
    step();
    wen = '0; raddr[AW +: AW] = 3'd6;
    step();
    check("hold_pre", rd(1), 16'h00AA);
    hold = 1'b1; wr(0, 3'd6, 16'h00BB); raddr[0 +: AW] = 3'd4;
    step();
    check("hold_c1_p1", rd(1), 16'h00AA);
    check("hold_c1_p0", rd(0), 16'h2222);
    wen = '0;
    step();
    check("hold_c2_p1", rd(1), 16'h00AA);
    step();
    check("hold_c3_p1", rd(1), 16'h00AA);
    hold = 1'b0;
    step();
    check("hold_release_p1", rd(1), 16'h00BB);
    check("hold_release_p0", rd(0), 16'h1234);

`ifdef REGFILE_SCOREBOARD_EN
    check("busy_reset", 16'(rbusy[0]), 16'h0000);
    claim = 1'b1; claim_addr = 3'd7; raddr[0 +: AW] = 3'd7;
    step();
    check("busy_claim", 16'(rbusy[0]), 16'h0001);
    claim = 1'b0;
    step();
    check("busy_kept", 16'(rbusy[0]), 16'h0001);
    wr(0, 3'd7, 16'h0777);
    step();
    check("busy_cleared", 16'(rbusy[0]), 16'h0000);
    check("busy_write_data", rd(0), 16'h0777);
    claim = 1'b1; wr(1, 3'd7, 16'h0888);
    step();
    check("busy_claim_wins", 16'(rbusy[0]), 16'h0001);
    wen = '0; claim_addr = 3'd0; raddr[AW +: AW] = 3'd0;
    step();
    check("busy_zero_never", 16'(rbusy[1]), 16'h0000);
    claim = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_regfile_mp

`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port successor of the pipeline CPU register file.
- Synchronous-read, write-first storage array with NREAD read ports and NWRITE write ports.
- Supports a hard-wired zero register, a read-hold (stall) control and a debug tap register.
- Sits between decode (read addresses) and writeback (write ports) in the pipelined CPU; also serves dual-issue experiments.

Parameters:
- WIDTH, 16: data width in bits.
- AW, 3: address width; depth = 2**AW.
- NREAD, 2: number of read ports (1..4).
- NWRITE, 1: number of write ports (1..2).
- ZERO_REG, 1: 1 = register 0 always reads 0 and ignores writes.
- TAP_REG, 3: index of the register driven onto tap_val.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- hold  in  1  1 = every rdata output keeps its previous value this cycle
- raddr  in  NREAD*AW  packed read addresses; port i at [i*AW +: AW]
- rdata  out  NREAD*WIDTH  packed registered read data
- wen  in  NWRITE  write enables
- waddr  in  NWRITE*AW  packed write addresses
- wdata  in  NWRITE*WIDTH  packed write data
- tap_val  out  WIDTH  combinational view of register TAP_REG (array contents, no bypass)
- claim  in  1  scoreboard claim strobe (present only with REGFILE_SCOREBOARD_EN)
- claim_addr  in  AW  register to mark busy (present only with REGFILE_SCOREBOARD_EN)
- rbusy  out  NREAD  per-read-port busy flag, registered (present only with REGFILE_SCOREBOARD_EN)

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst.
- Reset:
  - all array entries, rdata, rbusy and scoreboard bits go to 0 at the next posedge;
  - rst dominates hold, wen and claim.
- Read:
  - latency is 1 cycle; rdata[i] at edge N+1 reflects raddr[i] sampled at edge N;
  - write-first bypass: if a write port writes raddr[i] in the same cycle, rdata[i] gets that wdata, not the stale array value (this changes the old read-before-write behaviour);
  - with ZERO_REG=1, raddr=0 always returns 0, including when a write to 0 is in flight.
- Write:
  - the array updates at the posedge when wen[j]=1;
  - writes to register 0 are dropped when ZERO_REG=1;
  - two write ports on the same address in the same cycle: the higher index port wins, for both the array and the bypass;
  - writes are unaffected by hold.
- hold:
  - rdata registers keep their value while hold=1;
  - a write to the held address does not update the held rdata;
  - after hold falls, the next edge samples the current raddr.
- tap_val: updates the cycle after a write to TAP_REG; reads 0 after reset.
- Widths: no arithmetic. Out-of-range parameters are rejected by elaboration-time checks.

Optional Feature:
- Macro REGFILE_SCOREBOARD_EN.
- When defined:
  - one busy bit per register;
  - claim=1 sets busy[claim_addr] at the posedge;
  - any wen[j] to an address clears its bit;
  - if claim and a write hit the same address in the same cycle, claim wins (bit set);
  - busy[0] is never set when ZERO_REG=1;
  - rbusy[i] is registered alongside rdata[i] and obeys hold;
  - rbusy uses the post-update busy value (write-first, same as the data bypass).
- When undefined: claim, claim_addr and rbusy ports and all scoreboard logic are absent.

Decomposition:
- Shared package regfile_pkg:
  - default WIDTH/AW constants;
  - the helper that computes the winning write port for an address.
- One natural sub-module: regfile_rd_port, one instance per read port. It holds the bypass mux, zero-register logic, hold register and rbusy register, generated NREAD times.

Test Plan:
- Reset: write 0xBEEF to r5, assert rst for 1 cycle, read r5 → rdata=0x0000; tap_val=0.
- Bypass: same cycle wen[0]=1, waddr=4, wdata=0x1234 and raddr[0]=4 → next edge rdata[0]=0x1234; the old design would return the prior value.
- Zero register: write 0xFFFF to r0, read r0 on both ports in the same cycle and the next → 0x0000 both times.
- Write conflict (NWRITE=2): port0 writes r2=0x1111 and port1 writes r2=0x2222 → read r2 returns 0x2222; tap on r3 unchanged.
- Hold: rdata[1]=0x00AA from r6; hold=1 for 3 cycles while r6 is written 0x00BB → rdata[1] stays 0x00AA; one edge after hold falls → 0x00BB.
- Scoreboard (macro defined): claim r7 → rbusy=1 on reading r7; write r7 → next read rbusy=0; claim and write r7 in the same cycle → rbusy=1.
